// File: rtl/iob_pbus_split_pkg.sv
// Shared width derivations and target encoding for the IOb N-way peripheral-bus splitter.
package iob_pbus_split_pkg;

    function automatic int sel_width(input int n_slaves);
        return (n_slaves > 1) ? $clog2(n_slaves) : 1;
    endfunction

    // One extra bit so the unmapped "ERR" target never aliases a real target index.
    function automatic int tgt_width(input int n_slaves);
        return sel_width(n_slaves) + 1;
    endfunction

    function automatic int err_tgt(input int n_slaves);
        return 1 << sel_width(n_slaves);
    endfunction

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_pbus_split_tracker.sv
// Outstanding-read tracker: counts accepted reads, remembers the target that owes responses,
// generates the upstream stall, and answers unmapped reads one cycle after acceptance.
module iob_pbus_split_tracker
    import iob_pbus_split_pkg::*;
#(
    parameter int N_SLAVES        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TGT_W           = tgt_width(N_SLAVES)
) (
    input  logic                clk,
    input  logic                cke,
    input  logic                rst,
    input  logic                is_read,
    input  logic                mapped,
    input  logic [TGT_W-1:0]    sel_tgt,
    input  logic                accept,
    input  logic [N_SLAVES-1:0] m_rvalid,
    output logic                stall,
    output logic [TGT_W-1:0]    cur_tgt,
    output logic                rsp_valid,
    output logic                err
);
    localparam int               CNT_W   = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]    cnt;
    logic                err_rvalid_q;
    logic [N_SLAVES-1:0] exp_mask;
    logic                acc_read;
    logic                unexpected;

    // Only the target owing responses may answer, and only while something is outstanding.
    always_comb begin
        exp_mask = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            exp_mask[i] = (cnt != '0) && (cur_tgt == TGT_W'(i));
        end
    end

    assign unexpected = |(m_rvalid & ~exp_mask);
    assign rsp_valid  = (|(m_rvalid & exp_mask)) | err_rvalid_q;
    assign acc_read   = accept & is_read;
    assign stall      = rst | ~cke
                      | (is_read & (cnt == CNT_MAX))
                      | (is_read & (cnt != '0) & (sel_tgt != cur_tgt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            cur_tgt      <= '0;
            err_rvalid_q <= 1'b0;
            err          <= 1'b0;
        end else if (cke) begin
            case ({acc_read, rsp_valid})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (acc_read) begin
                cur_tgt <= sel_tgt;
            end
            err_rvalid_q <= acc_read & ~mapped;
            err          <= (accept & ~mapped) | unexpected;
        end
    end

endmodule

// File: rtl/iob_pbus_split_n.sv
// N-way IOb peripheral-bus splitter: decodes the upper address bits, fans requests out to the
// selected manager port and returns read data in order, with an error responder for holes.
module iob_pbus_split_n
    import iob_pbus_split_pkg::*;
#(
    parameter int N_SLAVES        = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter logic [DATA_W-1:0] ERR_DATA = '0,
    localparam int SEL_W  = sel_width(N_SLAVES),
    localparam int DA_W   = ADDR_W - SEL_W,
    localparam int STRB_W = strb_width(DATA_W)
) (
    input  logic                         clk_i,
    input  logic                         cke_i,
    input  logic                         arst_i,
    input  logic                         iob_valid_i,
    input  logic [ADDR_W-1:0]            iob_addr_i,
    input  logic [DATA_W-1:0]            iob_wdata_i,
    input  logic [STRB_W-1:0]            iob_wstrb_i,
    output logic                         iob_rvalid_o,
    output logic [DATA_W-1:0]            iob_rdata_o,
    output logic                         iob_ready_o,
    output logic [N_SLAVES-1:0]          m_valid_o,
    output logic [N_SLAVES*DA_W-1:0]     m_addr_o,
    output logic [N_SLAVES*DATA_W-1:0]   m_wdata_o,
    output logic [N_SLAVES*STRB_W-1:0]   m_wstrb_o,
    input  logic [N_SLAVES-1:0]          m_rvalid_i,
    input  logic [N_SLAVES*DATA_W-1:0]   m_rdata_i,
    input  logic [N_SLAVES-1:0]          m_ready_i,
    output logic                         err_o,
    output logic [ADDR_W-1:0]            err_addr_o
);
    localparam int               TGT_W   = tgt_width(N_SLAVES);
    localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(err_tgt(N_SLAVES));

    logic [SEL_W-1:0] sel;
    logic [TGT_W-1:0] sel_tgt;
    logic [TGT_W-1:0] cur_tgt;
    logic             mapped;
    logic             is_read;
    logic             stall;
    logic             tgt_ready;
    logic             accept;
    logic             rsp_valid;

    assign sel     = iob_addr_i[ADDR_W-1 -: SEL_W];
    assign is_read = (iob_wstrb_i == '0);
    assign sel_tgt = mapped ? {1'b0, sel} : ERR_TGT;

    always_comb begin
        mapped = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                mapped = 1'b1;
            end
        end
    end

    // Address, data and strobes go to every port; only m_valid_o qualifies the target.
    always_comb begin
        m_valid_o = '0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_wstrb_o = '0;
        tgt_ready = 1'b1;
        for (int i = 0; i < N_SLAVES; i++) begin
            m_addr_o[i*DA_W +: DA_W]       = iob_addr_i[DA_W-1:0];
            m_wdata_o[i*DATA_W +: DATA_W]  = iob_wdata_i;
            m_wstrb_o[i*STRB_W +: STRB_W]  = iob_wstrb_i;
            if (mapped && (sel == SEL_W'(i))) begin
                m_valid_o[i] = iob_valid_i & ~stall;
                tgt_ready    = m_ready_i[i];
            end
        end
    end

    assign iob_ready_o = ~stall & tgt_ready;
    assign accept      = iob_valid_i & iob_ready_o;

    always_comb begin
        iob_rdata_o = ERR_DATA;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (cur_tgt == TGT_W'(i)) begin
                iob_rdata_o = m_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign iob_rvalid_o = rsp_valid;

    iob_pbus_split_tracker #(
        .N_SLAVES        (N_SLAVES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TGT_W           (TGT_W)
    ) u_tracker (
        .clk       (clk_i),
        .cke       (cke_i),
        .rst       (arst_i),
        .is_read   (is_read),
        .mapped    (mapped),
        .sel_tgt   (sel_tgt),
        .accept    (accept),
        .m_rvalid  (m_rvalid_i),
        .stall     (stall),
        .cur_tgt   (cur_tgt),
        .rsp_valid (rsp_valid),
        .err       (err_o)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_addr_o <= '0;
        end else if (cke_i && accept && !mapped) begin
            err_addr_o <= iob_addr_i;
        end
    end

endmodule

// File: tb/tb_iob_pbus_split_n.sv
// Directed bench for iob_pbus_split_n: a 3-way instance with latency-programmable slaves and a
// 2-way instance for the basic write fan-out.
module tb_iob_pbus_split_n;

    typedef struct {
        logic        cke;
        logic        valid;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [2:0]  mready;
        logic [2:0]  exp_mvalid;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        arst, cke, iob_valid;
    logic [31:0] iob_addr, iob_wdata;
    logic [3:0]  iob_wstrb;

    logic        rvalid3, ready3, err3;
    logic [31:0] rdata3, err_addr3;
    logic [2:0]  m3_valid, m3_rvalid, m3_ready;
    logic [89:0] m3_addr;
    logic [95:0] m3_wdata, m3_rdata;
    logic [11:0] m3_wstrb;

    logic        rvalid2, ready2, err2;
    logic [31:0] rdata2, err_addr2;
    logic [1:0]  m2_valid;
    logic [1:0]  m2_rvalid = 2'b00;
    logic [1:0]  m2_ready  = 2'b11;
    logic [61:0] m2_addr;
    logic [63:0] m2_wdata;
    logic [63:0] m2_rdata  = '0;
    logic [7:0]  m2_wstrb;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat[3];
    logic        drv[3];
    rsp_t        sq[3][$];
    logic [31:0] exp_q[$];
    vec_t        vecs[8];

    always #5 clk = ~clk;

    iob_pbus_split_n #(.N_SLAVES(3), .ERR_DATA(ERR_D)) dut3 (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
        .iob_wstrb_i(iob_wstrb), .iob_rvalid_o(rvalid3), .iob_rdata_o(rdata3),
        .iob_ready_o(ready3), .m_valid_o(m3_valid), .m_addr_o(m3_addr),
        .m_wdata_o(m3_wdata), .m_wstrb_o(m3_wstrb), .m_rvalid_i(m3_rvalid),
        .m_rdata_i(m3_rdata), .m_ready_i(m3_ready), .err_o(err3), .err_addr_o(err_addr3)
    );

    iob_pbus_split_n #(.N_SLAVES(2)) dut2 (
        .clk_i(clk), .cke_i(cke), .arst_i(arst),
        .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
        .iob_wstrb_i(iob_wstrb), .iob_rvalid_o(rvalid2), .iob_rdata_o(rdata2),
        .iob_ready_o(ready2), .m_valid_o(m2_valid), .m_addr_o(m2_addr),
        .m_wdata_o(m2_wdata), .m_wstrb_o(m2_wstrb), .m_rvalid_i(m2_rvalid),
        .m_rdata_i(m2_rdata), .m_ready_i(m2_ready), .err_o(err2), .err_addr_o(err_addr2)
    );

    function automatic logic [31:0] slave_data(input int t, input logic [29:0] a);
        return {4'hA, 4'(t), 8'h00, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: score responses and record accepts on pre-edge values, then update slaves.
    task automatic tick();
        rsp_t r;
        @(posedge clk);
        if (cke && !arst) begin
            if (rvalid3) begin
                if (exp_q.size() == 0) chk("rsp_extra", {63'd0, rvalid3}, 64'd0);
                else chk("rsp_data", {32'd0, rdata3}, {32'd0, exp_q.pop_front()});
            end
            if (iob_valid && ready3 && iob_wstrb == 4'd0) begin
                if (iob_addr[31:30] == 2'b11) exp_q.push_back(ERR_D);
                else exp_q.push_back(slave_data(int'(iob_addr[31:30]), iob_addr[29:0]));
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (drv[i]) sq[i].delete(0);
            if (m3_valid[i] && m3_ready[i] && iob_wstrb == 4'd0) begin
                r.due  = cyc + lat[i];
                r.data = slave_data(i, m3_addr[i*30 +: 30]);
                sq[i].push_back(r);
            end
        end
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            drv[i] = (sq[i].size() != 0) && (sq[i][0].due < cyc);
            m3_rvalid[i] = drv[i];
            m3_rdata[i*32 +: 32] = drv[i] ? sq[i][0].data : 32'd0;
        end
    endtask

    task automatic wait_ready(input string name, input int max, output int waited);
        waited = 0;
        while (!ready3 && waited < max) begin
            tick();
            #2;
            waited++;
        end
        chk(name, {63'd0, ready3}, 64'd1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_read(input logic [31:0] a);
        iob_valid = 1'b1;
        iob_addr  = a;
        iob_wstrb = 4'd0;
    endtask

    initial begin
        int waited;
        int errs;
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0040, 4'hF, 3'b111, 3'b001, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 32'h4000_0044, 4'hF, 3'b111, 3'b010, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 32'h8000_0048, 4'hF, 3'b111, 3'b100, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'hC000_004C, 4'hF, 3'b111, 3'b000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h4000_0050, 4'h0, 3'b101, 3'b010, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0000, 4'h0, 3'b111, 3'b000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0000, 4'hF, 3'b111, 3'b000, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h8000_0054, 4'h3, 3'b011, 3'b100, 1'b0};

        for (int i = 0; i < 3; i++) begin
            lat[i] = 1;
            drv[i] = 1'b0;
        end
        arst = 1'b1; cke = 1'b1; iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0;
        iob_wstrb = '0; m3_ready = 3'b111; m3_rvalid = '0; m3_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("rst_rvalid", {63'd0, rvalid3}, 64'd0);
        chk("rst_err", {63'd0, err3}, 64'd0);
        chk("rst_err_addr", {32'd0, err_addr3}, 64'd0);
        chk("rst_mvalid", {61'd0, m3_valid}, 64'd0);
        chk("rst_ready", {63'd0, ready3}, 64'd0);
        @(posedge clk);
        #1 arst = 1'b0;

        // Combinational decode table; valid dropped before each edge so nothing is accepted
        for (int v = 0; v < 8; v++) begin
            cke = vecs[v].cke; iob_valid = vecs[v].valid; iob_addr = vecs[v].addr;
            iob_wstrb = vecs[v].wstrb; m3_ready = vecs[v].mready;
            iob_wdata = 32'h5A5A_0000 | 32'(v);
            #2;
            chk($sformatf("vec%0d_mvalid", v), {61'd0, m3_valid}, {61'd0, vecs[v].exp_mvalid});
            chk($sformatf("vec%0d_ready", v), {63'd0, ready3}, {63'd0, vecs[v].exp_ready});
            chk($sformatf("vec%0d_addr1", v), {34'd0, m3_addr[30 +: 30]}, {34'd0, vecs[v].addr[29:0]});
            chk($sformatf("vec%0d_wstrb1", v), {60'd0, m3_wstrb[4 +: 4]}, {60'd0, vecs[v].wstrb});
            chk($sformatf("vec%0d_wdata2", v), {32'd0, m3_wdata[64 +: 32]}, {32'd0, 32'h5A5A_0000 | 32'(v)});
            iob_valid = 1'b0; cke = 1'b1; m3_ready = 3'b111;
            tick();
        end

        // Two-way writes: low half then high half of the address map
        iob_valid = 1'b1; iob_addr = 32'h0000_0010; iob_wdata = 32'h1122_3344; iob_wstrb = 4'hF;
        #2;
        chk("w2_mvalid_lo", {62'd0, m2_valid}, 64'd1);
        chk("w2_addr_lo", {33'd0, m2_addr[0 +: 31]}, 64'h10);
        chk("w2_wdata_lo", {32'd0, m2_wdata[31:0]}, 64'h1122_3344);
        chk("w2_ready_lo", {63'd0, ready2}, 64'd1);
        tick();
        iob_addr = 32'h8000_0010;
        #2;
        chk("w2_mvalid_hi", {62'd0, m2_valid}, 64'd2);
        chk("w2_addr_hi", {33'd0, m2_addr[31 +: 31]}, 64'h10);
        chk("w2_wdata_hi", {32'd0, m2_wdata[63:32]}, 64'h1122_3344);
        tick();
        iob_valid = 1'b0;

        // Four reads in flight to target 0; the fifth waits for the first response
        lat[0] = 3;
        for (int k = 0; k < 4; k++) begin
            set_read(32'h0000_0100 + 32'(4 * k));
            #2;
            chk($sformatf("rd%0d_ready", k), {63'd0, ready3}, 64'd1);
            tick();
        end
        set_read(32'h0000_0110);
        #2;
        chk("rd4_stall", {63'd0, ready3}, 64'd0);
        chk("rd4_rvalid", {63'd0, rvalid3}, 64'd1);
        wait_ready("rd4_ready", 20, waited);
        chk("rd4_wait", 64'(waited), 64'd1);
        tick();
        iob_valid = 1'b0;
        drain(40);

        // Target switch is held until the older target has answered
        lat[0] = 5; lat[1] = 1;
        set_read(32'h0000_0020);
        #2;
        chk("sw_rd0_ready", {63'd0, ready3}, 64'd1);
        tick();
        set_read(32'h4000_0030);
        #2;
        chk("sw_rd1_stall", {63'd0, ready3}, 64'd0);
        chk("sw_rd1_mvalid", {61'd0, m3_valid}, 64'd0);
        wait_ready("sw_rd1_ready", 30, waited);
        chk("sw_rd1_wait", 64'(waited), 64'd6);
        tick();
        iob_valid = 1'b0;
        drain(40);

        // Unmapped reads back to back
        set_read(32'hC000_0000);
        #2;
        chk("ur0_ready", {63'd0, ready3}, 64'd1);
        chk("ur0_mvalid", {61'd0, m3_valid}, 64'd0);
        tick();
        set_read(32'hC000_0004);
        #2;
        chk("ur0_rvalid", {63'd0, rvalid3}, 64'd1);
        chk("ur0_rdata", {32'd0, rdata3}, {32'd0, ERR_D});
        chk("ur0_err", {63'd0, err3}, 64'd1);
        chk("ur0_err_addr", {32'd0, err_addr3}, 64'hC000_0000);
        chk("ur1_ready", {63'd0, ready3}, 64'd1);
        tick();
        set_read(32'hC000_0008);
        #2;
        chk("ur1_rvalid", {63'd0, rvalid3}, 64'd1);
        chk("ur1_err_addr", {32'd0, err_addr3}, 64'hC000_0004);
        chk("ur2_ready", {63'd0, ready3}, 64'd1);
        tick();
        iob_valid = 1'b0;
        #2;
        chk("ur2_rvalid", {63'd0, rvalid3}, 64'd1);
        tick();
        #2;
        chk("ur_done_rvalid", {63'd0, rvalid3}, 64'd0);

        // Unmapped write: accepted, discarded, flagged
        iob_valid = 1'b1; iob_addr = 32'hC000_0100; iob_wstrb = 4'hF;
        #2;
        chk("uw_ready", {63'd0, ready3}, 64'd1);
        tick();
        iob_valid = 1'b0;
        #2;
        chk("uw_err", {63'd0, err3}, 64'd1);
        chk("uw_err_addr", {32'd0, err_addr3}, 64'hC000_0100);
        chk("uw_rvalid", {63'd0, rvalid3}, 64'd0);
        tick();

        // Stray rvalid with nothing outstanding
        m3_rvalid[1] = 1'b1;
        #2;
        chk("stray_rvalid", {63'd0, rvalid3}, 64'd0);
        tick();
        #2;
        chk("stray_err", {63'd0, err3}, 64'd1);
        tick();
        #2;
        chk("stray_err_clr", {63'd0, err3}, 64'd0);

        // Clock enable low holds the error response
        set_read(32'hC000_0200);
        #2;
        chk("cke_ur_ready", {63'd0, ready3}, 64'd1);
        tick();
        cke = 1'b0; iob_valid = 1'b0;
        #2;
        chk("cke_rvalid0", {63'd0, rvalid3}, 64'd1);
        tick();
        set_read(32'h0000_0000);
        #2;
        chk("cke_rvalid1", {63'd0, rvalid3}, 64'd1);
        chk("cke_ready", {63'd0, ready3}, 64'd0);
        iob_valid = 1'b0; cke = 1'b1;
        tick();
        #2;
        chk("cke_rvalid_clr", {63'd0, rvalid3}, 64'd0);

        // Reset with three reads outstanding; their late responses become errors
        lat[0] = 8;
        for (int k = 0; k < 3; k++) begin
            set_read(32'h0000_0300 + 32'(4 * k));
            #2;
            chk($sformatf("ar_rd%0d_ready", k), {63'd0, ready3}, 64'd1);
            tick();
        end
        iob_valid = 1'b0;
        arst = 1'b1;
        #2;
        chk("ar_ready", {63'd0, ready3}, 64'd0);
        chk("ar_rvalid", {63'd0, rvalid3}, 64'd0);
        chk("ar_err", {63'd0, err3}, 64'd0);
        chk("ar_err_addr", {32'd0, err_addr3}, 64'd0);
        chk("ar_mvalid", {61'd0, m3_valid}, 64'd0);
        exp_q.delete();
        tick();
        arst = 1'b0;
        set_read(32'h4000_0060);
        #2;
        chk("ar_new_ready", {63'd0, ready3}, 64'd1);
        tick();
        iob_valid = 1'b0;
        errs = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            #2;
            if (err3) errs++;
        end
        chk("ar_late_errs", 64'(errs), 64'd3);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
